instr_encoder: RTL and testbench

Instruction encoder and loader for the single-cycle MIPS datapath: the writer-side counterpart of the opcode decoder in the control unit. Accepts symbolic instructions (operation class plus register/immediate fields) over a valid/ready handshake, packs them into 32-bit MIPS words using the team's opcode map (including the custom BRV, JMXOR, BLEZAL, BALV, JALPC, NANDI instructions), and streams them into consecutive instruction-memory words through a stallable write port. Used by the bench and the boot path to fill instruction memory before the core is released.

---
 rtl/instr_encoder.sv | 171 +++++++++++++++++
 tb/tb_instr_encoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instructions into 32-bit words and streams them into
// consecutive instruction-memory words through a stallable write port.
//
// Optional feature: define ENC_ILLEGAL_TRAP_EN to drop illegal classes (10-15) with a one-cycle
// err pulse. When undefined, illegal classes encode as NOP (32'h0) and err is tied 0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, finish           one-cycle control pulses (arm loading / end loading)
//   in_valid, in_ready      instruction-field handshake
//   in_class, in_rs, in_rt, in_rd, in_funct, in_imm   symbolic instruction fields
//   imem_we, imem_addr, imem_wdata, imem_ready        instruction-memory write port
//   count, full, busy, err  status

module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        finish,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_class,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [5:0]  in_funct,
   input  logic [15:0] in_imm,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   input  logic        imem_ready,
   output logic [15:0] count,
   output logic        full,
   output logic        busy,
   output logic        err
);

`ifdef ENC_ILLEGAL_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

   state_e      state_q, state_d;
   logic        pend_q, pend_d;
   logic [31:0] data_q, data_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] count_q, count_d;
   logic        fin_q, fin_d;
   logic        err_q, err_d;

   logic [31:0] enc_word;
   logic        illegal;
   logic        complete;
   logic        accept;
   logic        load_word;

   // Instruction packing
   always_comb begin
      enc_word = 32'h0;
      illegal  = 1'b0;
      case (in_class)
         4'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
         4'd1:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
         4'd2:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
         4'd3:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
         4'd4:    enc_word = {6'b100100, in_rs, in_rt, in_imm};
         4'd5:    enc_word = {6'b100000, in_rs, in_rt, in_imm};
         4'd6:    enc_word = {6'b011111, in_rs, in_rt, in_imm};
         4'd7:    enc_word = {6'b010000, in_rs, in_rt, in_imm};
         4'd8:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b010100};
         4'd9:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b010110};
         default: illegal  = 1'b1;
      endcase
   end

   // A pending word completing this cycle frees the slot for a same-cycle accept.
   // Acceptance also stops once finish has been seen, so no writes start after it.
   assign in_ready = (state_q == StLoad) && !fin_q && (!pend_q || imem_ready) &&
                     (({16'd0, count_q} + {31'd0, pend_q}) < DEPTH);

   assign complete  = pend_q & imem_ready;
   assign accept    = in_valid & in_ready & ~start & ~finish;
   assign load_word = accept & ~(TrapEn & illegal);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      data_d  = data_q;
      addr_d  = addr_q;
      count_d = count_q;
      fin_d   = fin_q;
      err_d   = accept & TrapEn & illegal;

      if (complete) begin
         pend_d  = 1'b0;
         count_d = count_q + 16'd1;
         addr_d  = addr_q + 32'd4;
      end
      if (load_word) begin
         pend_d = 1'b1;
         data_d = enc_word;
      end

      case (state_q)
         StIdle: begin
            if (start) state_d = StLoad;
         end
         StLoad: begin
            if (finish || fin_q) begin
               // Hold in LOAD until the last pending write has drained
               if (!pend_d) begin
                  state_d = StIdle;
                  fin_d   = 1'b0;
               end else begin
                  fin_d = 1'b1;
               end
            end else if (complete && ({16'd0, count_d} == DEPTH)) begin
               state_d = StFull;
            end
         end
         StFull: begin
            if (finish) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // start overrides everything: discard pending write and restart counters
      if (start) begin
         state_d = StLoad;
         pend_d  = 1'b0;
         addr_d  = BASE_ADDR;
         count_d = 16'd0;
         fin_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pend_q  <= 1'b0;
         data_q  <= 32'h0;
         addr_q  <= BASE_ADDR;
         count_q <= 16'd0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
      end
   end

   assign imem_we    = pend_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = data_q;
   assign count      = count_q;
   assign full       = ({16'd0, count_q} == DEPTH);
   assign busy       = (state_q == StLoad) || pend_q;
   assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   localparam logic [31:0] Base = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        finish = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_class = 4'd0;
   logic [4:0]  in_rs = 5'd0;
   logic [4:0]  in_rt = 5'd0;
   logic [4:0]  in_rd = 5'd0;
   logic [5:0]  in_funct = 6'd0;
   logic [15:0] in_imm = 16'd0;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        imem_ready = 1'b1;
   logic [15:0] count;
   logic        full;
   logic        busy;
   logic        err;

   instr_encoder #(.BASE_ADDR(Base), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_ready(imem_ready), .count(count), .full(full), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   wr_prev = 0;
   int   wr_last = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Scoreboard monitor: every completed write must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && imem_we && imem_ready) begin
         wr_prev = wr_last;
         wr_last = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", imem_addr, 32'hxxxx_xxxx);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_addr", imem_addr, e.addr);
            chk("write_data", imem_wdata, e.data);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm);
      bit done = 1'b0;
      in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = fn; in_imm = imm;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
      end
      if (!done) begin
         chk("send_accept_timeout", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_we", {31'd0, imem_we}, 32'd0);
      chk("rst_addr", imem_addr, Base);
      chk("rst_wdata", imem_wdata, 32'h0);
      chk("rst_count", {16'd0, count}, 32'd0);
      chk("rst_flags", {28'd0, full, busy, err, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LW
      imem_ready = 1'b1;
      pulse_start();
      push(Base, 32'h8C22_0004);
      send(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004);
      @(negedge clk);
      chk("lw_we", {31'd0, imem_we}, 32'd1);
      chk("lw_count_before", {16'd0, count}, 32'd0);
      @(negedge clk);
      chk("lw_count_after", {16'd0, count}, 32'd1);
      chk("lw_we_drop", {31'd0, imem_we}, 32'd0);

      // BRV then JMXOR back-to-back; in_funct must be ignored
      @(posedge clk); #1;
      pulse_start();
      push(Base, 32'h0064_2814);
      push(Base + 32'd4, 32'h0022_1816);
      send(4'd8, 5'd3, 5'd4, 5'd5, 6'h3F, 16'hFFFF);
      send(4'd9, 5'd1, 5'd2, 5'd3, 6'h3F, 16'hFFFF);
      @(negedge clk);
      @(negedge clk);
      chk("b2b_gap", wr_last - wr_prev, 32'd1);
      chk("b2b_count", {16'd0, count}, 32'd2);

      // SW stalled for 3 cycles
      @(posedge clk); #1;
      pulse_start();
      imem_ready = 1'b0;
      push(Base, 32'hACE8_FFFC);
      send(4'd2, 5'd7, 5'd8, 5'd0, 6'd0, 16'hFFFC);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_we", {31'd0, imem_we}, 32'd1);
         chk("stall_addr", imem_addr, Base);
         chk("stall_data", imem_wdata, 32'hACE8_FFFC);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("stall_count", {16'd0, count}, 32'd1);
      chk("stall_we_drop", {31'd0, imem_we}, 32'd0);

      // Fill to DEPTH=4 with NANDI
      @(posedge clk); #1;
      pulse_start();
      for (int i = 1; i <= 4; i++) begin
         push(Base + 32'(4 * (i - 1)), 32'h4043_0000 | 32'(i));
         send(4'd7, 5'd2, 5'd3, 5'd0, 6'd0, 16'(i));
      end
      @(negedge clk);
      @(negedge clk);
      chk("full_flag", {31'd0, full}, 32'd1);
      chk("full_count", {16'd0, count}, 32'd4);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      in_class = 4'd7;
      in_valid = 1'b1;
      @(negedge clk);
      chk("full_no_accept", {30'd0, in_ready, imem_we}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      pulse_start();
      @(negedge clk);
      chk("restart_count", {16'd0, count}, 32'd0);
      chk("restart_addr", imem_addr, Base);
      chk("restart_flags", {30'd0, full, in_ready}, 32'd1);

      // Illegal class 12
      @(posedge clk); #1;
      pulse_start();
`ifdef ENC_ILLEGAL_TRAP_EN
      send(4'd12, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1234);
      @(negedge clk);
      chk("illegal_err", {31'd0, err}, 32'd1);
      chk("illegal_no_we", {31'd0, imem_we}, 32'd0);
      @(negedge clk);
      chk("illegal_err_drop", {31'd0, err}, 32'd0);
      chk("illegal_count", {16'd0, count}, 32'd0);
`else
      push(Base, 32'h0000_0000);
      send(4'd12, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1234);
      @(negedge clk);
      chk("illegal_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      chk("illegal_count", {16'd0, count}, 32'd1);
`endif

      // finish while a write is pending
      @(posedge clk); #1;
      pulse_start();
      imem_ready = 1'b0;
      push(Base, 32'h8C85_0010);
      send(4'd1, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0010);
      finish = 1'b1;
      @(posedge clk); #1;
      finish = 1'b0;
      @(negedge clk);
      chk("fin_pending", {29'd0, busy, imem_we, in_ready}, 32'd6);
      @(posedge clk); #1;
      imem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("fin_idle", {30'd0, busy, in_ready}, 32'd0);
      chk("fin_count", {16'd0, count}, 32'd1);

      // Reset while a write is pending
      @(posedge clk); #1;
      pulse_start();
      imem_ready = 1'b0;
      send(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we", {31'd0, imem_we}, 32'd0);
      chk("rst_mid_count", {16'd0, count}, 32'd0);
      chk("rst_mid_state", {30'd0, busy, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      imem_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_we_after", {31'd0, imem_we}, 32'd0);

      @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
